// File: rtl/framebuffer_scanout_pkg.sv
// -----------------------------------------------------------------------------
// framebuffer_scanout_pkg
// Shared definitions for the framebuffer scanout slice:
//   - video-mode timing constants (640x480 @ 60 Hz) and the timing record
//     carried from the timing generator to the scanout pipeline
//   - buffer configuration (dimensions, upscale, pixel/address widths) and
//     the 4:4:4 RGB field slicing helpers
//   - the buffer-swap FSM state encoding
// -----------------------------------------------------------------------------
package framebuffer_scanout_pkg;

    // ---- video mode --------------------------------------------------------
    localparam int VM_H_ACTIVE = 640;
    localparam int VM_H_FP     = 16;
    localparam int VM_H_SYNC   = 96;
    localparam int VM_H_BP     = 48;
    localparam int VM_V_ACTIVE = 480;
    localparam int VM_V_FP     = 10;
    localparam int VM_V_SYNC   = 2;
    localparam int VM_V_BP     = 33;
    localparam bit VM_SYNC_POL = 1'b0;

    // Counter width covers modes up to 4095 pixels/lines total.
    localparam int CNT_W = 12;
    typedef logic [CNT_W-1:0] cnt_t;

    // Timing record for the current pixel position (undelayed).
    typedef struct packed {
        cnt_t h_cnt;
        cnt_t v_cnt;
        logic active;
        logic hsync;
        logic vsync;
    } timing_t;

    // ---- buffer configuration ---------------------------------------------
    localparam int FB_BUF_W  = 160;
    localparam int FB_BUF_H  = 120;
    localparam int FB_SCALE  = 4;
    localparam int FB_DATA_W = 12;
    localparam int FB_ADDR_W = 15;

    typedef logic [11:0] pixel_t;
    typedef logic [3:0]  chan_t;

    function automatic chan_t pix_red(input pixel_t p);
        return p[11:8];
    endfunction

    function automatic chan_t pix_green(input pixel_t p);
        return p[7:4];
    endfunction

    function automatic chan_t pix_blue(input pixel_t p);
        return p[3:0];
    endfunction

    // ---- buffer swap FSM ---------------------------------------------------
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SWAP = 1'b1
    } swap_state_e;

endpackage

// File: rtl/framebuffer_scanout_if.sv
// -----------------------------------------------------------------------------
// framebuffer_scanout_if
// Framebuffer-side bundle of the scanout block.
//   read_addr      scanout -> memory   pixel read address
//   read_data      memory  -> scanout  pixel data, valid 1 cycle after read_addr
//   frame_ready    drawer  -> scanout  inactive buffer finished (level)
//   swap_ack       scanout -> drawer   one-cycle pulse when a swap is taken
//   buffer_select  scanout -> memory   index of the buffer being displayed
// master = scanout side, slave = memory/drawing side.
// -----------------------------------------------------------------------------
interface framebuffer_scanout_if #(
    parameter int DATA_W = 12,
    parameter int ADDR_W = 15
);
    logic [ADDR_W-1:0] read_addr;
    logic [DATA_W-1:0] read_data;
    logic              frame_ready;
    logic              swap_ack;
    logic              buffer_select;

    modport master (
        output read_addr,
        output swap_ack,
        output buffer_select,
        input  read_data,
        input  frame_ready
    );

    modport slave (
        input  read_addr,
        input  swap_ack,
        input  buffer_select,
        output read_data,
        output frame_ready
    );
endinterface

// File: rtl/framebuffer_scanout_timing.sv
// -----------------------------------------------------------------------------
// scanout_timing
// Horizontal/vertical pixel counters and raw (undelayed) sync/active flags.
//   clk_display   in   pixel clock
//   rstn_display  in   asynchronous active-low reset
//   tim           out  timing record for the current position
//   h_nxt, v_nxt  out  position the counters take on the next clock edge
// -----------------------------------------------------------------------------
module scanout_timing
    import framebuffer_scanout_pkg::*;
#(
    parameter int H_ACTIVE = VM_H_ACTIVE,
    parameter int H_FP     = VM_H_FP,
    parameter int H_SYNC   = VM_H_SYNC,
    parameter int H_BP     = VM_H_BP,
    parameter int V_ACTIVE = VM_V_ACTIVE,
    parameter int V_FP     = VM_V_FP,
    parameter int V_SYNC   = VM_V_SYNC,
    parameter int V_BP     = VM_V_BP,
    parameter bit SYNC_POL = VM_SYNC_POL
) (
    input  logic    clk_display,
    input  logic    rstn_display,
    output timing_t tim,
    output cnt_t    h_nxt,
    output cnt_t    v_nxt
);

    localparam cnt_t H_LAST   = cnt_t'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam cnt_t V_LAST   = cnt_t'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam cnt_t H_ACT    = cnt_t'(H_ACTIVE);
    localparam cnt_t V_ACT    = cnt_t'(V_ACTIVE);
    localparam cnt_t HS_START = cnt_t'(H_ACTIVE + H_FP);
    localparam cnt_t HS_END   = cnt_t'(H_ACTIVE + H_FP + H_SYNC);
    localparam cnt_t VS_START = cnt_t'(V_ACTIVE + V_FP);
    localparam cnt_t VS_END   = cnt_t'(V_ACTIVE + V_FP + V_SYNC);

    cnt_t h_cnt;
    cnt_t v_cnt;

    // NOTE: every always_comb output gets a default first so no path can leave it unassigned (which would infer a latch).
    always_comb begin
        h_nxt = h_cnt + cnt_t'(1);
        v_nxt = v_cnt;
        if (h_cnt == H_LAST) begin
            h_nxt = '0;
            v_nxt = (v_cnt == V_LAST) ? '0 : v_cnt + cnt_t'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values regardless of block order.
    always_ff @(posedge clk_display or negedge rstn_display) begin
        if (!rstn_display) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else begin
            h_cnt <= h_nxt;
            v_cnt <= v_nxt;
        end
    end

    always_comb begin
        tim.h_cnt  = h_cnt;
        tim.v_cnt  = v_cnt;
        tim.active = (h_cnt < H_ACT) && (v_cnt < V_ACT);
        tim.hsync  = ((h_cnt >= HS_START) && (h_cnt < HS_END)) ? SYNC_POL : ~SYNC_POL;
        tim.vsync  = ((v_cnt >= VS_START) && (v_cnt < VS_END)) ? SYNC_POL : ~SYNC_POL;
    end

endmodule

// File: rtl/framebuffer_scanout.sv
// -----------------------------------------------------------------------------
// framebuffer_scanout
// Scans a BUF_W x BUF_H double-buffered framebuffer out to VGA, upscaled by
// SCALE in both directions, with a frame-synchronous buffer swap.
//   clk_display   in   pixel clock
//   rstn_display  in   asynchronous active-low reset
//   fb            bus  framebuffer read port + swap handshake (master side)
//   vga_hsync/vsync    out  sync outputs (SYNC_POL = active level)
//   vga_red/green/blue out  4-bit colour, zero outside the active region
// Pipeline: counters + read_addr aligned at cycle t, data at t+1, all pins
// registered together at t+2.
// -----------------------------------------------------------------------------
module framebuffer_scanout
    import framebuffer_scanout_pkg::*;
#(
    parameter int H_ACTIVE = VM_H_ACTIVE,
    parameter int H_FP     = VM_H_FP,
    parameter int H_SYNC   = VM_H_SYNC,
    parameter int H_BP     = VM_H_BP,
    parameter int V_ACTIVE = VM_V_ACTIVE,
    parameter int V_FP     = VM_V_FP,
    parameter int V_SYNC   = VM_V_SYNC,
    parameter int V_BP     = VM_V_BP,
    parameter bit SYNC_POL = VM_SYNC_POL,
    parameter int BUF_W    = FB_BUF_W,
    parameter int BUF_H    = FB_BUF_H,
    parameter int SCALE    = FB_SCALE,
    parameter int DATA_W   = FB_DATA_W,
    parameter int ADDR_W   = FB_ADDR_W
) (
    input  logic                  clk_display,
    input  logic                  rstn_display,
    framebuffer_scanout_if.master fb,
    output logic                  vga_hsync,
    output logic                  vga_vsync,
    output logic [3:0]            vga_red,
    output logic [3:0]            vga_green,
    output logic [3:0]            vga_blue
);

    if ((H_ACTIVE != BUF_W * SCALE) || (V_ACTIVE != BUF_H * SCALE) ||
        (SCALE < 1) || ((SCALE & (SCALE - 1)) != 0) || (DATA_W != 12)) begin : g_bad_cfg
        $error("framebuffer_scanout: inconsistent buffer/mode configuration");
    end

    localparam cnt_t H_ACT      = cnt_t'(H_ACTIVE);
    localparam cnt_t V_ACT      = cnt_t'(V_ACTIVE);
    localparam cnt_t SCALE_MASK = cnt_t'(SCALE - 1);

    timing_t tim;
    cnt_t    h_nxt;
    cnt_t    v_nxt;

    scanout_timing #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP),
        .SYNC_POL (SYNC_POL)
    ) u_timing (
        .clk_display  (clk_display),
        .rstn_display (rstn_display),
        .tim          (tim),
        .h_nxt        (h_nxt),
        .v_nxt        (v_nxt)
    );

    // ---- address generation ------------------------------------------------
    // Registers are loaded from the *next* counter position so read_addr is
    // aligned with the counters in the same cycle. row_base tracks
    // (v/SCALE)*BUF_W, the column steps every SCALE pixels; outside the active
    // region the address simply holds.
    logic [ADDR_W-1:0] row_base;
    logic [ADDR_W-1:0] row_base_nxt;
    logic [ADDR_W-1:0] read_addr_q;
    logic [ADDR_W-1:0] addr_nxt;
    logic              nxt_active;

    always_comb begin
        row_base_nxt = row_base;
        if (h_nxt == '0) begin
            if (v_nxt == '0) begin
                row_base_nxt = '0;
            end else if (((v_nxt & SCALE_MASK) == '0) && (v_nxt < V_ACT)) begin
                row_base_nxt = row_base + ADDR_W'(BUF_W);
            end
        end

        nxt_active = (h_nxt < H_ACT) && (v_nxt < V_ACT);
        addr_nxt   = read_addr_q;
        if (nxt_active) begin
            if (h_nxt == '0) begin
                addr_nxt = row_base_nxt;
            end else if ((h_nxt & SCALE_MASK) == '0) begin
                addr_nxt = read_addr_q + ADDR_W'(1);
            end
        end
    end

    always_ff @(posedge clk_display or negedge rstn_display) begin
        if (!rstn_display) begin
            row_base    <= '0;
            read_addr_q <= '0;
        end else begin
            row_base    <= row_base_nxt;
            read_addr_q <= addr_nxt;
        end
    end

    assign fb.read_addr = read_addr_q;

    // ---- output pipeline ---------------------------------------------------
    // Stage 1 holds the flags while the memory returns data; stage 2 is the
    // pins, so colour, syncs and blanking leave the block in the same cycle.
    logic d1_active;
    logic d1_hsync;
    logic d1_vsync;

    // NOTE: pipeline flags are reset too so the pins come out of reset blanked with syncs inactive, not showing stale flags.
    always_ff @(posedge clk_display or negedge rstn_display) begin
        if (!rstn_display) begin
            d1_active <= 1'b0;
            d1_hsync  <= ~SYNC_POL;
            d1_vsync  <= ~SYNC_POL;
            vga_hsync <= ~SYNC_POL;
            vga_vsync <= ~SYNC_POL;
            vga_red   <= '0;
            vga_green <= '0;
            vga_blue  <= '0;
        end else begin
            d1_active <= tim.active;
            d1_hsync  <= tim.hsync;
            d1_vsync  <= tim.vsync;
            vga_hsync <= d1_hsync;
            vga_vsync <= d1_vsync;
            vga_red   <= d1_active ? pix_red(fb.read_data)   : 4'h0;
            vga_green <= d1_active ? pix_green(fb.read_data) : 4'h0;
            vga_blue  <= d1_active ? pix_blue(fb.read_data)  : 4'h0;
        end
    end

    // ---- buffer swap FSM ---------------------------------------------------
    // The swap point (h=0, first blank line) is well past the last active
    // pixel in flight, so toggling buffer_select there never tears a frame.
    swap_state_e state;
    logic        buffer_select_q;
    logic        swap_ack_q;
    logic        swap_point;

    assign swap_point = (tim.h_cnt == '0) && (tim.v_cnt == V_ACT);

    always_ff @(posedge clk_display or negedge rstn_display) begin
        if (!rstn_display) begin
            state           <= ST_IDLE;
            buffer_select_q <= 1'b0;
            swap_ack_q      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    swap_ack_q <= 1'b0;
                    if (swap_point && fb.frame_ready) begin
                        state           <= ST_SWAP;
                        buffer_select_q <= ~buffer_select_q;
                        swap_ack_q      <= 1'b1;
                    end
                end
                ST_SWAP: begin
                    state      <= ST_IDLE;
                    swap_ack_q <= 1'b0;
                end
                default: begin
                    state      <= ST_IDLE;
                    swap_ack_q <= 1'b0;
                end
            endcase
        end
    end

    assign fb.buffer_select = buffer_select_q;
    assign fb.swap_ack      = swap_ack_q;

endmodule

// File: tb/tb_framebuffer_scanout.sv
// -----------------------------------------------------------------------------
// tb_framebuffer_scanout
// Two instances: one in the default 640x480 mode for line-level behaviour,
// one in a tiny mode (16x12 visible, 24x17 total, SCALE 2) so whole frames
// and buffer swaps fit in a short run. Each memory returns addr[11:0] one
// cycle after read_addr. Outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_framebuffer_scanout;

    // default mode
    localparam int B_HT = 800, B_VT = 525, B_HA = 640, B_VA = 480;
    localparam int B_HFP = 16, B_HS = 96, B_VFP = 10, B_VS = 2;
    localparam int B_BW = 160, B_SC = 4;
    // tiny mode
    localparam int S_HA = 16, S_HFP = 2, S_HS = 4, S_HBP = 2, S_HT = 24;
    localparam int S_VA = 12, S_VFP = 1, S_VS = 2, S_VBP = 2, S_VT = 17;
    localparam int S_BW = 8, S_BH = 6, S_SC = 2;
    localparam int S_FRAME = S_HT * S_VT;

    logic clk_display = 1'b0;
    logic rstn_display;

    always #5 clk_display = ~clk_display;

    framebuffer_scanout_if #(.DATA_W(12), .ADDR_W(15)) fb_big ();
    framebuffer_scanout_if #(.DATA_W(12), .ADDR_W(15)) fb_small ();

    logic       big_hs, big_vs, small_hs, small_vs;
    logic [3:0] big_r, big_g, big_b, small_r, small_g, small_b;

    framebuffer_scanout dut_big (
        .clk_display  (clk_display),
        .rstn_display (rstn_display),
        .fb           (fb_big),
        .vga_hsync    (big_hs),
        .vga_vsync    (big_vs),
        .vga_red      (big_r),
        .vga_green    (big_g),
        .vga_blue     (big_b)
    );

    framebuffer_scanout #(
        .H_ACTIVE (S_HA), .H_FP (S_HFP), .H_SYNC (S_HS), .H_BP (S_HBP),
        .V_ACTIVE (S_VA), .V_FP (S_VFP), .V_SYNC (S_VS), .V_BP (S_VBP),
        .SYNC_POL (1'b0),
        .BUF_W    (S_BW), .BUF_H (S_BH), .SCALE (S_SC),
        .DATA_W   (12),   .ADDR_W (15)
    ) dut_small (
        .clk_display  (clk_display),
        .rstn_display (rstn_display),
        .fb           (fb_small),
        .vga_hsync    (small_hs),
        .vga_vsync    (small_vs),
        .vga_red      (small_r),
        .vga_green    (small_g),
        .vga_blue     (small_b)
    );

    // synchronous memories: data = address, one cycle later
    always @(posedge clk_display) begin
        fb_big.read_data   <= fb_big.read_addr[11:0];
        fb_small.read_data <= fb_small.read_addr[11:0];
    end

    int checks   = 0;
    int failures = 0;

    // ---- expected-value helpers (c = cycles since reset release) ----------
    function automatic int exp_addr(input int c, input int ht, input int vt, input int ha,
                                    input int va, input int bw, input int sc);
        int h, v;
        h = c % ht;
        v = (c / ht) % vt;
        if (v >= va) return (va / sc - 1) * bw + (ha / sc - 1);
        if (h >= ha) return (v / sc) * bw + (ha / sc - 1);
        return (v / sc) * bw + h / sc;
    endfunction

    function automatic int exp_rgb(input int c, input int ht, input int vt, input int ha,
                                   input int va, input int bw, input int sc);
        int p;
        if (c < 2) return 0;
        p = c - 2;
        if ((p % ht) < ha && ((p / ht) % vt) < va) return exp_addr(p, ht, vt, ha, va, bw, sc) & 'hfff;
        return 0;
    endfunction

    function automatic logic exp_hs(input int c, input int ht, input int ha, input int fp, input int sw);
        int h;
        if (c < 2) return 1'b1;
        h = (c - 2) % ht;
        return !(h >= ha + fp && h < ha + fp + sw);
    endfunction

    function automatic logic exp_vs(input int c, input int ht, input int vt, input int va,
                                    input int fp, input int sw);
        int v;
        if (c < 2) return 1'b1;
        v = ((c - 2) / ht) % vt;
        return !(v >= va + fp && v < va + fp + sw);
    endfunction

    task automatic step();
        @(posedge clk_display);
        @(negedge clk_display);
    endtask

    // ---- tests -------------------------------------------------------------
    task automatic test_reset();
        rstn_display         = 1'b0;
        fb_big.frame_ready   = 1'b0;
        fb_small.frame_ready = 1'b0;
        @(negedge clk_display);
        repeat (3) step();
        checks++; if (fb_big.read_addr !== 15'd0) begin failures++; $display("FAIL reset_addr got %0d want 0", fb_big.read_addr); end
        checks++; if (fb_big.buffer_select !== 1'b0) begin failures++; $display("FAIL reset_bufsel got %b want 0", fb_big.buffer_select); end
        checks++; if (fb_big.swap_ack !== 1'b0) begin failures++; $display("FAIL reset_ack got %b want 0", fb_big.swap_ack); end
        checks++; if ({big_r, big_g, big_b} !== 12'h000) begin failures++; $display("FAIL reset_rgb got %h want 000", {big_r, big_g, big_b}); end
        checks++; if (big_hs !== 1'b1) begin failures++; $display("FAIL reset_hsync got %b want 1", big_hs); end
        checks++; if (big_vs !== 1'b1) begin failures++; $display("FAIL reset_vsync got %b want 1", big_vs); end
        checks++;
        if ({fb_small.read_addr, fb_small.buffer_select, fb_small.swap_ack, small_r, small_g, small_b, small_hs, small_vs}
            !== {15'd0, 1'b0, 1'b0, 12'h000, 1'b1, 1'b1}) begin
            failures++;
            $display("FAIL reset_small got addr=%0d sel=%b ack=%b rgb=%h hs=%b vs=%b want 0/0/0/000/1/1",
                     fb_small.read_addr, fb_small.buffer_select, fb_small.swap_ack,
                     {small_r, small_g, small_b}, small_hs, small_vs);
        end
        rstn_display = 1'b1;  // released at a falling edge: cycle 0 = (0,0)
    endtask

    // First lines of the default mode: address, pixel data, blanking, hsync.
    task automatic test_first_lines();
        int ea, er, hs_low, hs_first;
        logic ehs, evs;
        hs_low   = 0;
        hs_first = -1;
        for (int c = 0; c <= 4 * B_HT + 300; c++) begin
            ea  = exp_addr(c, B_HT, B_VT, B_HA, B_VA, B_BW, B_SC);
            er  = exp_rgb(c, B_HT, B_VT, B_HA, B_VA, B_BW, B_SC);
            ehs = exp_hs(c, B_HT, B_HA, B_HFP, B_HS);
            evs = exp_vs(c, B_HT, B_VT, B_VA, B_VFP, B_VS);
            checks++; if (fb_big.read_addr !== 15'(ea)) begin failures++; $display("FAIL big_addr c=%0d got %0d want %0d", c, fb_big.read_addr, ea); end
            checks++; if ({big_r, big_g, big_b} !== 12'(er)) begin failures++; $display("FAIL big_rgb c=%0d got %h want %h", c, {big_r, big_g, big_b}, 12'(er)); end
            checks++; if (big_hs !== ehs) begin failures++; $display("FAIL big_hsync c=%0d got %b want %b", c, big_hs, ehs); end
            checks++; if (big_vs !== evs) begin failures++; $display("FAIL big_vsync c=%0d got %b want %b", c, big_vs, evs); end
            checks++; if (fb_big.buffer_select !== 1'b0 || fb_big.swap_ack !== 1'b0) begin
                failures++; $display("FAIL big_noswap c=%0d got sel=%b ack=%b want 0/0", c, fb_big.buffer_select, fb_big.swap_ack);
            end
            if (c < B_HT + 2 && big_hs === 1'b0) begin
                hs_low++;
                if (hs_first < 0) hs_first = c;
            end
            if (c == 4 * B_HT) begin
                checks++; if (fb_big.read_addr !== 15'd160) begin failures++; $display("FAIL addr_h0_v4 got %0d want 160", fb_big.read_addr); end
            end
            if (c < 4 * B_HT + 300) step();
        end
        checks++; if (hs_low !== 96) begin failures++; $display("FAIL hsync_width got %0d want 96", hs_low); end
        checks++; if (hs_first !== 658) begin failures++; $display("FAIL hsync_start got %0d want 658", hs_first); end
    endtask

    // Now at (h=300, v=4) with non-zero address and pixels on the pins.
    task automatic test_reset_midframe();
        int ea, er;
        #2;
        rstn_display = 1'b0;
        #1;  // clock still low: no edge has occurred since reset went low
        checks++; if (fb_big.read_addr !== 15'd0) begin failures++; $display("FAIL mid_reset_addr got %0d want 0", fb_big.read_addr); end
        checks++; if ({big_r, big_g, big_b} !== 12'h000) begin failures++; $display("FAIL mid_reset_rgb got %h want 000", {big_r, big_g, big_b}); end
        checks++; if (big_hs !== 1'b1 || big_vs !== 1'b1) begin failures++; $display("FAIL mid_reset_sync got %b%b want 11", big_hs, big_vs); end
        checks++; if (fb_big.buffer_select !== 1'b0 || fb_big.swap_ack !== 1'b0) begin
            failures++; $display("FAIL mid_reset_swap got sel=%b ack=%b want 0/0", fb_big.buffer_select, fb_big.swap_ack);
        end
        @(negedge clk_display);
        step();
        rstn_display = 1'b1;
        for (int c = 0; c <= 10; c++) begin
            ea = exp_addr(c, B_HT, B_VT, B_HA, B_VA, B_BW, B_SC);
            er = exp_rgb(c, B_HT, B_VT, B_HA, B_VA, B_BW, B_SC);
            checks++; if (fb_big.read_addr !== 15'(ea)) begin failures++; $display("FAIL restart_addr c=%0d got %0d want %0d", c, fb_big.read_addr, ea); end
            checks++; if ({big_r, big_g, big_b} !== 12'(er)) begin failures++; $display("FAIL restart_rgb c=%0d got %h want %h", c, {big_r, big_g, big_b}, 12'(er)); end
            if (c < 10) step();
        end
    endtask

    // Tiny mode, 6 frames: addressing across whole frames, vsync, frame
    // period, and swaps. frame_ready is high for frames 0-2 (3 swaps), then
    // pulsed mid-frame 3 and low by the swap point (no swap), then low.
    task automatic test_swap_frames();
        int ea, er, acks, toggles, falls, last_fall, n_cyc;
        logic ehs, evs, eack, esel, prev_sel, prev_vs;
        rstn_display = 1'b0;
        step();
        step();
        rstn_display = 1'b1;
        acks      = 0;
        toggles   = 0;
        falls     = 0;
        last_fall = -1;
        prev_sel  = 1'b0;
        prev_vs   = 1'b1;
        n_cyc     = 6 * S_FRAME;
        for (int c = 0; c <= n_cyc; c++) begin
            fb_small.frame_ready = (c < 3 * S_FRAME) ||
                                   (c >= 3 * S_FRAME + 3 * S_HT && c < 3 * S_FRAME + 4 * S_HT);
            ea   = exp_addr(c, S_HT, S_VT, S_HA, S_VA, S_BW, S_SC);
            er   = exp_rgb(c, S_HT, S_VT, S_HA, S_VA, S_BW, S_SC);
            ehs  = exp_hs(c, S_HT, S_HA, S_HFP, S_HS);
            evs  = exp_vs(c, S_HT, S_VT, S_VA, S_VFP, S_VS);
            // swap point (0,12) is cycle 288 of each frame; ack one cycle later
            eack = (c == 289) || (c == 289 + S_FRAME) || (c == 289 + 2 * S_FRAME);
            esel = (c >= 289) ^ (c >= 289 + S_FRAME) ^ (c >= 289 + 2 * S_FRAME);
            checks++; if (fb_small.read_addr !== 15'(ea)) begin failures++; $display("FAIL small_addr c=%0d got %0d want %0d", c, fb_small.read_addr, ea); end
            checks++; if ({small_r, small_g, small_b} !== 12'(er)) begin failures++; $display("FAIL small_rgb c=%0d got %h want %h", c, {small_r, small_g, small_b}, 12'(er)); end
            checks++; if (small_hs !== ehs) begin failures++; $display("FAIL small_hsync c=%0d got %b want %b", c, small_hs, ehs); end
            checks++; if (small_vs !== evs) begin failures++; $display("FAIL small_vsync c=%0d got %b want %b", c, small_vs, evs); end
            checks++; if (fb_small.swap_ack !== eack) begin failures++; $display("FAIL swap_ack c=%0d got %b want %b", c, fb_small.swap_ack, eack); end
            checks++; if (fb_small.buffer_select !== esel) begin failures++; $display("FAIL buffer_select c=%0d got %b want %b", c, fb_small.buffer_select, esel); end
            if (c == 11 * S_HT + 15) begin
                checks++; if (fb_small.read_addr !== 15'd47) begin failures++; $display("FAIL last_addr got %0d want 47", fb_small.read_addr); end
            end
            if (fb_small.swap_ack === 1'b1) acks++;
            if (fb_small.buffer_select !== prev_sel) toggles++;
            prev_sel = fb_small.buffer_select;
            if (prev_vs === 1'b1 && small_vs === 1'b0) begin
                if (last_fall >= 0) begin
                    checks++; if (c - last_fall !== S_FRAME) begin failures++; $display("FAIL frame_period got %0d want %0d", c - last_fall, S_FRAME); end
                end
                last_fall = c;
                falls++;
            end
            prev_vs = small_vs;
            if (c < n_cyc) step();
        end
        checks++; if (acks !== 3) begin failures++; $display("FAIL ack_count got %0d want 3", acks); end
        checks++; if (toggles !== 3) begin failures++; $display("FAIL toggle_count got %0d want 3", toggles); end
        checks++; if (falls !== 6) begin failures++; $display("FAIL vsync_frames got %0d want 6", falls); end
        checks++; if (last_fall !== 314 + 5 * S_FRAME) begin failures++; $display("FAIL vsync_last_fall got %0d want %0d", last_fall, 314 + 5 * S_FRAME); end
        fb_small.frame_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_first_lines();
        test_reset_midframe();
        test_swap_frames();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // run-length guard
    initial begin
        #2000000;
        $display("FAIL watchdog expired at time %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
